// File: rtl/spi_dma_rc.sv
// spi_dma_rc: DMA read channel. Issues credit-checked Avalon burst reads and pushes the returned words into the TX FIFO.
// Latency: a request registers one cycle after the run is started; each response is pushed combinationally in its arrival cycle.
// Backpressure: a request holds until biu_rdy. No burst is issued unless the FIFO has room for every outstanding word, so responses are never stalled.
// Optional feature: define SPI_DMA_RC_4K_EN to clip bursts at 4 KB address boundaries.
module spi_dma_rc #(
   parameter int AL = 2,
   parameter int AW = 32,
   parameter int BL = 4,
   parameter int FW = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pio_adr_we,
   input  logic                  pio_len_we,
   input  logic [31:0]           pio_d,
   input  logic [BL:0]           burstcount,
   output logic [31:0]           pio_adr,
   output logic [31:0]           pio_len,
   output logic [31:0]           pio_cst,
   input  logic [FW:0]           dff_cnt,
   output logic                  dff_wr,
   output logic [8*(2**AL)-1:0]  dff_d,
   output logic                  done,
   output logic [AW-1:0]         biu_adr,
   output logic [BL:0]           biu_len,
   output logic                  biu_val,
   input  logic                  biu_rdy,
   input  logic                  rsp_val,
   input  logic [8*(2**AL)-1:0]  rsp_dat
);

   localparam int LW = BL + 1;
   localparam int OW = FW + 1;
   localparam int CW = FW + 2;
   localparam logic [BL:0] MAXB = LW'(2**BL);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state;
   logic [31:0]   adr_q;
   logic [31:0]   len_q;
   logic [FW:0]   osd;
   logic          done_flag;
   logic          err;
   logic          abort_q;

   logic          busy;
   logic          acc;
   logic          rsp_ok;
   logic          abort_now;
   logic          abort_apply;
   logic [BL:0]   eb;
   logic [BL:0]   req_len;
   logic [CW-1:0] credit;
   logic          issue;
   logic [FW:0]   osd_nxt;
   logic [31:0]   len_nxt;
`ifdef SPI_DMA_RC_4K_EN
   logic [12:0]   room;
   logic [12:0]   room_w;
`endif

   assign pio_adr = adr_q;
   assign pio_len = len_q;
   assign dff_wr  = rsp_ok;
   assign dff_d   = rsp_dat;

   // Handshake decode, abort timing and next counter values
   always_comb begin
      busy        = (state != IDLE);
      acc         = biu_val & biu_rdy;
      rsp_ok      = rsp_val & (osd != '0);
      // An abort waits for a pending request to be accepted before it zeroes the length
      abort_now   = busy & ((pio_len_we & (pio_d == 32'd0)) | abort_q);
      abort_apply = abort_now & (~biu_val | biu_rdy);
      len_nxt     = abort_apply ? 32'd0 : (len_q - (acc ? 32'(biu_len) : 32'd0));
      osd_nxt     = osd + (acc ? OW'(biu_len) : OW'(0)) - (rsp_ok ? OW'(1) : OW'(0));
   end

   // Burst length selection and FIFO credit check for the next request
   always_comb begin
      eb = burstcount;
      if (burstcount == '0)
         eb = LW'(1);
      else if (burstcount > MAXB)
         eb = MAXB;
      req_len = eb;
      if (len_q < 32'(eb))
         req_len = len_q[BL:0];
`ifdef SPI_DMA_RC_4K_EN
      room   = 13'd4096 - {1'b0, adr_q[11:0]};
      room_w = room >> AL;
      if (room_w < 13'(req_len))
         req_len = room_w[BL:0];
`endif
      credit = CW'(dff_cnt) + CW'(osd) + CW'(req_len);
      issue  = (state == RUN) & ~biu_val & (len_q != 32'd0) & ~abort_now &
               (credit <= CW'(2**FW));
   end

   // Status word assembly
   always_comb begin
      pio_cst         = '0;
      pio_cst[0]      = busy;
      pio_cst[1]      = done_flag;
      pio_cst[2]      = err;
      pio_cst[FW+8:8] = osd;
   end

   // Run-control FSM with registered request, counters and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         adr_q     <= '0;
         len_q     <= '0;
         osd       <= '0;
         done_flag <= 1'b0;
         err       <= 1'b0;
         abort_q   <= 1'b0;
         done      <= 1'b0;
         biu_val   <= 1'b0;
         biu_adr   <= '0;
         biu_len   <= '0;
      end else begin
         done <= 1'b0;
         osd  <= osd_nxt;
         if (pio_len_we) begin
            done_flag <= 1'b0;
            err       <= 1'b0;
         end
         if (rsp_val && (osd == '0))
            err <= 1'b1;
         if (acc)
            adr_q <= adr_q + (32'(biu_len) << AL);

         if (acc) begin
            biu_val <= 1'b0;
         end else if (issue) begin
            biu_val <= 1'b1;
            biu_adr <= adr_q[AW-1:0];
            biu_len <= req_len;
         end

         if (abort_apply)
            abort_q <= 1'b0;
         else if (abort_now)
            abort_q <= 1'b1;

         case (state)
            IDLE: begin
               if (pio_adr_we)
                  adr_q <= pio_d & ~((32'd1 << AL) - 32'd1);
               if (pio_len_we && (pio_d != 32'd0)) begin
                  len_q <= pio_d;
                  state <= RUN;
               end
            end
            RUN, DRAIN: begin
               len_q <= len_nxt;
               if (len_nxt == 32'd0) begin
                  if (osd_nxt == '0) begin
                     state     <= IDLE;
                     done      <= 1'b1;
                     done_flag <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_dma_rc.sv
// tb_spi_dma_rc: randomized bench for the DMA read channel against a burst-splitting reference model.
// A memory model answers accepted bursts in order with random gaps; requests and pushes are logged and compared per scenario.
// Credit and handshake-stability rules are watched on every cycle.
module tb_spi_dma_rc;

   localparam int AL = 2;
   localparam int AW = 32;
   localparam int BL = 4;
   localparam int FW = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pio_adr_we = 1'b0;
   logic          pio_len_we = 1'b0;
   logic [31:0]   pio_d = '0;
   logic [BL:0]   burstcount = '0;
   logic [31:0]   pio_adr;
   logic [31:0]   pio_len;
   logic [31:0]   pio_cst;
   logic [FW:0]   dff_cnt = '0;
   logic          dff_wr;
   logic [DW-1:0] dff_d;
   logic          done;
   logic [AW-1:0] biu_adr;
   logic [BL:0]   biu_len;
   logic          biu_val;
   logic          biu_rdy = 1'b0;
   logic          rsp_val = 1'b0;
   logic [DW-1:0] rsp_dat = '0;

   spi_dma_rc #(.AL(AL), .AW(AW), .BL(BL), .FW(FW)) dut (
      .clk(clk), .rst_n(rst_n), .pio_adr_we(pio_adr_we), .pio_len_we(pio_len_we),
      .pio_d(pio_d), .burstcount(burstcount), .pio_adr(pio_adr), .pio_len(pio_len),
      .pio_cst(pio_cst), .dff_cnt(dff_cnt), .dff_wr(dff_wr), .dff_d(dff_d), .done(done),
      .biu_adr(biu_adr), .biu_len(biu_len), .biu_val(biu_val), .biu_rdy(biu_rdy),
      .rsp_val(rsp_val), .rsp_dat(rsp_dat)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   bit rsp_en = 1'b0;
   bit inject = 1'b0;
   bit rdy_rand = 1'b0;
   bit cnt_rand = 1'b0;

   logic [31:0] rq[$];
   logic [31:0] obs_adr[$];
   int          obs_len[$];
   logic [31:0] obs_push[$];
   int          done_cnt = 0;

   logic [31:0] exp_adr[$];
   int          exp_len[$];
   logic [31:0] exp_dat[$];

   int          tb_osd = 0;
   int          prev_credit = 0;
   bit          prev_val = 1'b0;
   bit          prev_rdy = 1'b0;
   logic [31:0] prev_adr = '0;
   logic [BL:0] prev_len = '0;
   int          credit_viol = 0;
   int          stab_viol = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Bus and FIFO monitor: logs traffic, tracks outstanding words, flags rule breaks
   always @(negedge clk) begin
      if (!rst_n) begin
         tb_osd   = 0;
         prev_val = 1'b0;
         prev_rdy = 1'b0;
      end else begin
         if (biu_val && (!prev_val || prev_rdy))
            if (prev_credit + int'(biu_len) > (1 << FW)) credit_viol++;
         if (prev_val && !prev_rdy)
            if (!biu_val || biu_adr !== prev_adr || biu_len !== prev_len) stab_viol++;
         prev_credit = int'(dff_cnt) + tb_osd;
         if (biu_val && biu_rdy) begin
            obs_adr.push_back(biu_adr);
            obs_len.push_back(int'(biu_len));
            for (int i = 0; i < int'(biu_len); i++) rq.push_back(mem_word(biu_adr + 32'(4 * i)));
            tb_osd += int'(biu_len);
         end
         if (dff_wr) begin
            obs_push.push_back(dff_d);
            tb_osd--;
         end
         if (done) done_cnt++;
         prev_val = biu_val;
         prev_rdy = biu_rdy;
         prev_adr = biu_adr;
         prev_len = biu_len;
      end
   end

   // Memory responder: returns queued burst data in order with random idle cycles
   always @(posedge clk) begin
      #2;
      if (inject) begin
         rsp_val = 1'b1;
         rsp_dat = $urandom;
      end else if (rsp_en && rq.size() > 0 && ($urandom % 4) != 0) begin
         rsp_val = 1'b1;
         rsp_dat = rq.pop_front();
      end else begin
         rsp_val = 1'b0;
         rsp_dat = '0;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: split a run into bursts from the length/clamp/boundary rules
   task automatic build_model(input logic [31:0] adr, input int len, input int bc);
      logic [31:0] a;
      int rem, n;
      exp_adr.delete(); exp_len.delete(); exp_dat.delete();
      a = adr & 32'hFFFF_FFFC;
      rem = len;
      while (rem > 0) begin
         n = (bc == 0) ? 1 : ((bc > 16) ? 16 : bc);
         if (n > rem) n = rem;
`ifdef SPI_DMA_RC_4K_EN
         if (n > (4096 - int'(a[11:0])) / 4) n = (4096 - int'(a[11:0])) / 4;
`endif
         exp_adr.push_back(a);
         exp_len.push_back(n);
         for (int i = 0; i < n; i++) exp_dat.push_back(mem_word(a + 32'(4 * i)));
         a = a + 32'(4 * n);
         rem -= n;
      end
   endtask

   task automatic start_run(input logic [31:0] adr, input int len, input int bc);
      @(posedge clk); #1;
      pio_adr_we = 1'b1; pio_d = adr;
      @(posedge clk); #1;
      pio_adr_we = 1'b0;
      burstcount = (BL + 1)'(bc);
      pio_len_we = 1'b1; pio_d = 32'(len);
      @(posedge clk); #1;
      pio_len_we = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int d0, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         if (rdy_rand) biu_rdy = ($urandom % 2) == 1;
         if (cnt_rand) dff_cnt = (FW + 1)'($urandom_range(0, 40));
         if (done_cnt > d0) begin ok = 1'b1; break; end
      end
      repeat (4) @(posedge clk);
      #1;
      if (cnt_rand) dff_cnt = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({biu_val, done, dff_wr} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b required 000", {biu_val, done, dff_wr}); end
      checks++; if (pio_adr !== 32'd0) begin errors++; $display("FAIL rst_adr: got %0h required 0", pio_adr); end
      checks++; if (pio_len !== 32'd0) begin errors++; $display("FAIL rst_len: got %0h required 0", pio_len); end
      checks++; if (pio_cst !== 32'd0) begin errors++; $display("FAIL rst_cst: got %0h required 0", pio_cst); end
      checks++; if (biu_adr !== '0 || biu_len !== '0) begin errors++; $display("FAIL rst_biu: got %0h/%0d required 0/0", biu_adr, biu_len); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (biu_val !== 1'b0 || pio_cst !== 32'd0) begin errors++; $display("FAIL post_rst: got val=%b cst=%0h required 0/0", biu_val, pio_cst); end
   endtask

   task automatic test_basic();
      int rb, pb, d0;
      bit ok;
      rb = obs_adr.size(); pb = obs_push.size(); d0 = done_cnt;
      biu_rdy = 1'b1; dff_cnt = '0; rsp_en = 1'b1;
      build_model(32'h1000, 40, 16);
      start_run(32'h1000, 40, 16);
      wait_done(800, d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done_wait: got timeout required done"); end
      checks++; if (obs_adr.size() - rb != exp_adr.size()) begin errors++; $display("FAIL basic_nreq: got %0d required %0d", obs_adr.size() - rb, exp_adr.size()); end
      for (int i = 0; i < exp_adr.size() && rb + i < obs_adr.size(); i++) begin
         checks++;
         if (obs_adr[rb+i] !== exp_adr[i] || obs_len[rb+i] != exp_len[i]) begin errors++; $display("FAIL basic_req%0d: got %0d@%0h required %0d@%0h", i, obs_len[rb+i], obs_adr[rb+i], exp_len[i], exp_adr[i]); end
      end
      checks++; if (obs_push.size() - pb != exp_dat.size()) begin errors++; $display("FAIL basic_npush: got %0d required %0d", obs_push.size() - pb, exp_dat.size()); end
      for (int i = 0; i < exp_dat.size() && pb + i < obs_push.size(); i++) begin
         checks++;
         if (obs_push[pb+i] !== exp_dat[i]) begin errors++; $display("FAIL basic_dat%0d: got %0h required %0h", i, obs_push[pb+i], exp_dat[i]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0); end
      checks++; if (pio_cst[2:0] !== 3'b010) begin errors++; $display("FAIL basic_cst: got %b required 010", pio_cst[2:0]); end
      checks++; if (pio_adr !== 32'h10A0 || pio_len !== 32'd0) begin errors++; $display("FAIL basic_final: got adr=%0h len=%0d required 10a0/0", pio_adr, pio_len); end
   endtask

   task automatic test_credit();
      int rb, pb, d0;
      bit ok;
      rb = obs_adr.size(); pb = obs_push.size(); d0 = done_cnt;
      biu_rdy = 1'b1; dff_cnt = 7'd60; rsp_en = 1'b0;
      build_model(32'h2000, 16, 8);
      start_run(32'h2000, 16, 8);
      repeat (20) @(posedge clk);
      #1;
      checks++; if (obs_adr.size() != rb || biu_val !== 1'b0) begin errors++; $display("FAIL credit_block: got reqs=%0d val=%b required 0/0", obs_adr.size() - rb, biu_val); end
      dff_cnt = 7'd56;
      for (int c = 0; c < 20 && obs_adr.size() == rb; c++) @(posedge clk);
      checks++; if (obs_adr.size() != rb + 1) begin errors++; $display("FAIL credit_release: got reqs=%0d required 1", obs_adr.size() - rb); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (obs_adr.size() != rb + 1) begin errors++; $display("FAIL credit_osd: got reqs=%0d required 1", obs_adr.size() - rb); end
      dff_cnt = '0; rsp_en = 1'b1;
      wait_done(800, d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL credit_done_wait: got timeout required done"); end
      checks++; if (obs_adr.size() - rb != exp_adr.size()) begin errors++; $display("FAIL credit_nreq: got %0d required %0d", obs_adr.size() - rb, exp_adr.size()); end
      for (int i = 0; i < exp_adr.size() && rb + i < obs_adr.size(); i++) begin
         checks++;
         if (obs_adr[rb+i] !== exp_adr[i] || obs_len[rb+i] != exp_len[i]) begin errors++; $display("FAIL credit_req%0d: got %0d@%0h required %0d@%0h", i, obs_len[rb+i], obs_adr[rb+i], exp_len[i], exp_adr[i]); end
      end
      checks++; if (obs_push.size() - pb != exp_dat.size()) begin errors++; $display("FAIL credit_npush: got %0d required %0d", obs_push.size() - pb, exp_dat.size()); end
   endtask

   task automatic test_stall();
      int rb, pb, d0;
      bit ok, seen;
      logic [AW-1:0] sa;
      logic [BL:0] sl;
      rb = obs_adr.size(); pb = obs_push.size(); d0 = done_cnt;
      biu_rdy = 1'b0; dff_cnt = '0; rsp_en = 1'b1;
      build_model(32'h3000, 8, 8);
      start_run(32'h3000, 8, 8);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = biu_val; end
      checks++; if (!seen) begin errors++; $display("FAIL stall_req: got no biu_val required request"); end
      sa = biu_adr; sl = biu_len;
      checks++; if (sa !== exp_adr[0] || int'(sl) != exp_len[0]) begin errors++; $display("FAIL stall_first: got %0d@%0h required %0d@%0h", sl, sa, exp_len[0], exp_adr[0]); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (biu_val !== 1'b1 || biu_adr !== sa || biu_len !== sl || obs_adr.size() != rb) begin
            errors++; $display("FAIL stall_hold%0d: got val=%b %0d@%0h acc=%0d required 1 %0d@%0h acc=0", c, biu_val, biu_len, biu_adr, obs_adr.size() - rb, sl, sa);
         end
      end
      biu_rdy = 1'b1;
      wait_done(400, d0, ok);
      checks++; if (!ok || obs_adr.size() != rb + 1) begin errors++; $display("FAIL stall_accept: got ok=%b reqs=%0d required 1/1", ok, obs_adr.size() - rb); end
      checks++; if (obs_push.size() - pb != exp_dat.size()) begin errors++; $display("FAIL stall_npush: got %0d required %0d", obs_push.size() - pb, exp_dat.size()); end
      for (int i = 0; i < exp_dat.size() && pb + i < obs_push.size(); i++) begin
         checks++;
         if (obs_push[pb+i] !== exp_dat[i]) begin errors++; $display("FAIL stall_dat%0d: got %0h required %0h", i, obs_push[pb+i], exp_dat[i]); end
      end
   endtask

   task automatic test_abort();
      int rb, pb, d0;
      bit ok, seen;
      rb = obs_adr.size(); pb = obs_push.size(); d0 = done_cnt;
      biu_rdy = 1'b1; dff_cnt = '0; rsp_en = 1'b1;
      build_model(32'h4000, 16, 16);
      start_run(32'h4000, 40, 16);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = biu_val && biu_rdy; end
      pio_d = 32'd0; pio_len_we = 1'b1;
      @(posedge clk); #1;
      pio_len_we = 1'b0;
      wait_done(800, d0, ok);
      checks++; if (!seen || !ok) begin errors++; $display("FAIL abort_flow: got seen=%b done=%b required 1/1", seen, ok); end
      checks++; if (obs_adr.size() - rb != 1 || obs_adr[rb] !== exp_adr[0] || obs_len[rb] != exp_len[0]) begin
         errors++; $display("FAIL abort_reqs: got %0d reqs required one 16@4000", obs_adr.size() - rb);
      end
      checks++; if (obs_push.size() - pb != exp_dat.size()) begin errors++; $display("FAIL abort_npush: got %0d required %0d", obs_push.size() - pb, exp_dat.size()); end
      for (int i = 0; i < exp_dat.size() && pb + i < obs_push.size(); i++) begin
         checks++;
         if (obs_push[pb+i] !== exp_dat[i]) begin errors++; $display("FAIL abort_dat%0d: got %0h required %0h", i, obs_push[pb+i], exp_dat[i]); end
      end
      checks++; if (done_cnt - d0 != 1 || pio_len !== 32'd0 || pio_cst[0] !== 1'b0) begin
         errors++; $display("FAIL abort_end: got pulses=%0d len=%0d busy=%b required 1/0/0", done_cnt - d0, pio_len, pio_cst[0]);
      end
   endtask

   task automatic test_stray();
      int pb;
      pb = obs_push.size();
      @(posedge clk); #1;
      inject = 1'b1;
      @(posedge clk); #1;
      inject = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (obs_push.size() != pb) begin errors++; $display("FAIL stray_push: got %0d pushes required 0", obs_push.size() - pb); end
      checks++; if (pio_cst[2] !== 1'b1) begin errors++; $display("FAIL stray_err: got %b required 1", pio_cst[2]); end
      pio_d = 32'd0; pio_len_we = 1'b1;
      @(posedge clk); #1;
      pio_len_we = 1'b0;
      @(posedge clk); #1;
      checks++; if (pio_cst[2:0] !== 3'b000) begin errors++; $display("FAIL stray_clear: got %b required 000", pio_cst[2:0]); end
   endtask

`ifdef SPI_DMA_RC_4K_EN
   task automatic test_4k();
      int rb, d0;
      bit ok;
      rb = obs_adr.size(); d0 = done_cnt;
      biu_rdy = 1'b1; dff_cnt = '0; rsp_en = 1'b1;
      start_run(32'h0FF8, 16, 16);
      wait_done(400, d0, ok);
      checks++; if (!ok || obs_adr.size() - rb != 2) begin errors++; $display("FAIL k4_nreq: got ok=%b reqs=%0d required 1/2", ok, obs_adr.size() - rb); end
      checks++; if (obs_adr.size() - rb == 2 && (obs_adr[rb] !== 32'h0FF8 || obs_len[rb] != 2 || obs_adr[rb+1] !== 32'h1000 || obs_len[rb+1] != 14)) begin
         errors++; $display("FAIL k4_split: got %0d@%0h %0d@%0h required 2@ff8 14@1000", obs_len[rb], obs_adr[rb], obs_len[rb+1], obs_adr[rb+1]);
      end
   endtask
`endif

   task automatic test_random();
      int rb, pb, d0, len, bc;
      logic [31:0] adr;
      bit ok;
      rdy_rand = 1'b1; cnt_rand = 1'b1; rsp_en = 1'b1;
      for (int r = 0; r < 12; r++) begin
         rb = obs_adr.size(); pb = obs_push.size(); d0 = done_cnt;
         adr = $urandom;
         len = $urandom_range(1, 100);
         bc = $urandom_range(0, 31);
         build_model(adr, len, bc);
         start_run(adr, len, bc);
         wait_done(4000, d0, ok);
         checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: got timeout required done", r); end
         checks++; if (obs_adr.size() - rb != exp_adr.size()) begin errors++; $display("FAIL rand%0d_nreq: got %0d required %0d", r, obs_adr.size() - rb, exp_adr.size()); end
         for (int i = 0; i < exp_adr.size() && rb + i < obs_adr.size(); i++) begin
            checks++;
            if (obs_adr[rb+i] !== exp_adr[i] || obs_len[rb+i] != exp_len[i]) begin errors++; $display("FAIL rand%0d_req%0d: got %0d@%0h required %0d@%0h", r, i, obs_len[rb+i], obs_adr[rb+i], exp_len[i], exp_adr[i]); end
         end
         checks++; if (obs_push.size() - pb != exp_dat.size()) begin errors++; $display("FAIL rand%0d_npush: got %0d required %0d", r, obs_push.size() - pb, exp_dat.size()); end
         for (int i = 0; i < exp_dat.size() && pb + i < obs_push.size(); i++) begin
            checks++;
            if (obs_push[pb+i] !== exp_dat[i]) begin errors++; $display("FAIL rand%0d_dat%0d: got %0h required %0h", r, i, obs_push[pb+i], exp_dat[i]); end
         end
      end
      rdy_rand = 1'b0; cnt_rand = 1'b0;
      checks++; if (credit_viol != 0) begin errors++; $display("FAIL credit_rule: got %0d violations required 0", credit_viol); end
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL hold_rule: got %0d violations required 0", stab_viol); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_credit();
      test_stall();
      test_abort();
      test_stray();
`ifdef SPI_DMA_RC_4K_EN
      test_4k();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_dma_rc.md
# spi_dma_rc

Read channel of the single-channel DMA: fetches a programmed range of words from the Avalon bus with burst reads and pushes the returned data into the transmit FIFO. It sits between the PIO register block, the bus interface unit (BIU) and the FIFO write port. It is the counterpart of the write channel.

- Burst issue is credit-based: a burst is requested only when the FIFO is guaranteed room for every outstanding word.
- Responses therefore never need back-pressure.

## Interface
Parameters:
- AL, 2, address LSB; data width DW = 8*(2**AL)
- AW, 32, bus address width
- BL, 4, burst length width; max burst 2**BL words; BL>0
- FW, 6, FIFO level width; FIFO size 2**FW; FW>=BL

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- pio_adr_we  in  1  write pio_d into start address; ignored while busy
- pio_len_we  in  1  write pio_d into word count; nonzero starts a run
- pio_d  in  32  PIO write data
- burstcount  in  BL+1  requested burst length in words
- pio_adr  out  32  next request byte address
- pio_len  out  32  words not yet requested
- pio_cst  out  32  status word:
  - [0] busy
  - [1] done (sticky)
  - [2] rsp error (sticky)
  - [FW+8:8] outstanding words
- dff_cnt  in  FW+1  FIFO fill level
- dff_wr  out  1  FIFO push
- dff_d  out  DW  FIFO push data
- done  out  1  one-cycle pulse at run completion
- biu_adr  out  AW  burst start byte address
- biu_len  out  BL+1  burst length in words
- biu_val  out  1  burst request valid
- biu_rdy  in  1  BIU accepts request
- rsp_val  in  1  read data valid
- rsp_dat  in  DW  read data

## Operation
- States:
  - IDLE: not busy.
  - RUN: pio_len != 0; bursts are issued.
  - DRAIN: pio_len == 0; osd != 0; waiting for responses.
- State transitions:
  - IDLE -> RUN when pio_len_we with pio_d != 0.
  - RUN -> DRAIN when the last request is accepted.
  - DRAIN -> IDLE when the last response arrives.
  - RUN -> IDLE directly only if osd == 0 at the final acceptance (not possible; osd >= 1).
- Address handling:
  - pio_adr_we stores pio_d with bits [AL-1:0] forced 0.
  - Bits above AW-1 are kept in pio_adr, but only [AW-1:0] drives biu_adr.
- Effective burst eb:
  - eb = burstcount clamped to the range 1..2**BL.
  - biu_len = min(eb, pio_len).
- Credit rule:
  - A request may be raised only when dff_cnt + osd + biu_len <= 2**FW.
  - This arithmetic is evaluated at FW+2 bits; no wrap.
- On acceptance (biu_val & biu_rdy):
  - pio_adr += biu_len << AL.
  - pio_len -= biu_len.
  - osd += biu_len.
- On rsp_val with osd != 0:
  - dff_wr = 1 and dff_d = rsp_dat in the same cycle, combinationally.
  - osd -= 1.
- Stray rsp_val with osd == 0: ignored; no FIFO push; pio_cst[2] is set.
- Simultaneous acceptance and rsp_val: osd += biu_len - 1.
- Abort: pio_len_we with pio_d == 0 while busy.
  - Sets pio_len to 0 once no request is pending.
  - If biu_val is high, the pending request completes first; the abort then applies.
  - Outstanding responses are still drained and pushed.
- pio_len_we with nonzero pio_d while busy: ignored.
- Done flag:
  - pio_cst[1] is set together with the done pulse.
  - pio_cst[1] and pio_cst[2] are cleared by pio_len_we.

## Timing
- Reset values:
  - biu_val=0, done=0, dff_wr=0.
  - pio_adr=0, pio_len=0, pio_cst=0, osd=0.
  - biu_adr=0, biu_len=0.
- biu_val, biu_adr and biu_len are registered.
- Request latency: biu_val rises no earlier than the cycle after pio_len_we.
- Handshake: once biu_val is high, biu_val, biu_adr and biu_len hold stable until the biu_rdy cycle.
- Back-to-back bursts:
  - The next request may be asserted in the cycle after acceptance.
  - Its credit is evaluated with the updated osd.
- done is registered; it pulses the cycle after the rsp_val that brings osd to 0 with pio_len == 0.
- rst_n assertion mid-run clears all state immediately. Responses arriving after reset are treated as stray.

## Configuration
- SPI_DMA_RC_4K_EN defined:
  - biu_len is further clipped so a burst never crosses a 4 KB boundary.
  - Clip value: (4096 - pio_adr[11:0]) >> AL words.
- Not defined: no boundary clipping.

## Test plan
- adr=0x1000, len=40, burstcount=16, FIFO empty, rdy=1 -> three requests:
  - 16@0x1000, 16@0x1040, 8@0x1080.
  - 40 dff_wr with data in order.
  - One done pulse; pio_cst[1]=1.
- FW=6, dff_cnt held at 60, len=16, burstcount=8:
  - No biu_val while dff_cnt + osd + 8 > 64.
  - Lowering dff_cnt to 56 -> request issued.
- biu_rdy held low 5 cycles -> biu_val, biu_adr and biu_len are stable for all 5 cycles. Acceptance occurs on the rdy cycle only.
- Abort: write len=0 after the first burst is accepted -> no further requests. The remaining responses of that burst are pushed, then done pulses.
- rsp_val in IDLE -> no dff_wr; pio_cst[2]=1. pio_len_we clears it.
- SPI_DMA_RC_4K_EN defined, adr=0x0FF8, len=16, burstcount=16, AL=2 -> bursts 2@0x0FF8, then 14@0x1000.
